// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display path.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active-low, with the dp bit left off.
package bcd_scan_display_pkg;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

    localparam logic [7:0] SSD_0     = 8'h03;
    localparam logic [7:0] SSD_1     = 8'h9F;
    localparam logic [7:0] SSD_2     = 8'h25;
    localparam logic [7:0] SSD_3     = 8'h0D;
    localparam logic [7:0] SSD_4     = 8'h99;
    localparam logic [7:0] SSD_5     = 8'h49;
    localparam logic [7:0] SSD_6     = 8'h41;
    localparam logic [7:0] SSD_7     = 8'h1F;
    localparam logic [7:0] SSD_8     = 8'h01;
    localparam logic [7:0] SSD_9     = 8'h09;
    localparam logic [7:0] SSD_DASH  = 8'hFD;
    localparam logic [7:0] SSD_BLANK = 8'hFF;

    localparam logic [3:0] SSD_DIGIT_OFF = 4'b1111;

endpackage

// File: rtl/bcd_scan_display_bcd_to_ssd.sv
// Combinational BCD digit to 7-segment pattern (a..g, active-low).
// Values A..F are not valid BCD and show a dash so a bad counter is visible.
module bcd_to_ssd
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // digit value to segment pattern lookup
    always_comb begin
        seg = SSD_DASH[7:1];
        case (bcd)
            4'd0:    seg = SSD_0[7:1];
            4'd1:    seg = SSD_1[7:1];
            4'd2:    seg = SSD_2[7:1];
            4'd3:    seg = SSD_3[7:1];
            4'd4:    seg = SSD_4[7:1];
            4'd5:    seg = SSD_5[7:1];
            4'd6:    seg = SSD_6[7:1];
            4'd7:    seg = SSD_7[7:1];
            4'd8:    seg = SSD_8[7:1];
            4'd9:    seg = SSD_9[7:1];
            default: seg = SSD_DASH[7:1];
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexes two packed-BCD pairs onto a 4-digit common-anode display.
// The counter value is snapshotted once per frame (at the idx 3->0 wrap) so a
// frame never mixes digits from two counter values. Digit drive stays off
// until the scan has made its first step after reset.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_DIV_W    = 16,
    parameter int BLINK_SCANS_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cnt_hi,
    input  logic [7:0] cnt_lo,
    input  logic       blank_lead,
    input  logic       sep_on,
    input  logic       blink_hi,
    input  logic       blink_lo,
    output logic [3:0] ssd_ctl,
    output logic [7:0] ssd_seg
);

    logic [SCAN_DIV_W-1:0]    div_q, div_d;
    logic [1:0]               idx_q, idx_d;
    logic [BLINK_SCANS_W-1:0] frame_q, frame_d;
    logic                     phase_q, phase_d;
    logic                     live_q, live_d;
    logic [15:0]              snap_q, snap_d;
    logic [3:0]               ctl_q, ctl_d;
    logic [7:0]               seg_q, seg_d;

    logic       scan_wrap, frame_wrap;
    logic       lz3, lz2, lz1;
    logic [3:0] digit_val;
    logic [6:0] digit_pat;
    logic       lz_cur, blink_cur, dp_cur;

    assign scan_wrap  = (div_q == {SCAN_DIV_W{1'b1}});
    assign frame_wrap = scan_wrap && (idx_q == 2'd3);

    // Leading-zero chain: a digit only blanks if everything above it blanked.
    // Invalid BCD values are nonzero here, so they are always displayed.
    assign lz3 = blank_lead && (snap_q[15:12] == 4'h0);
    assign lz2 = lz3 && (snap_q[11:8] == 4'h0);
    assign lz1 = lz2 && (snap_q[7:4] == 4'h0);

    // scan divider, digit index, per-frame snapshot and blink phase
    always_comb begin
        div_d   = div_q + SCAN_DIV_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        phase_d = phase_q;
        live_d  = live_q;
        snap_d  = snap_q;
        if (scan_wrap) begin
            idx_d  = idx_q + 2'd1;
            live_d = ENABLED;
        end
        if (frame_wrap) begin
            snap_d  = {cnt_hi, cnt_lo};
            frame_d = frame_q + BLINK_SCANS_W'(1);
            if (frame_q == {BLINK_SCANS_W{1'b1}}) begin
                phase_d = ~phase_q;
            end
        end
    end

    // select the digit being scanned and its blanking/blink qualifiers
    always_comb begin
        digit_val = snap_q[3:0];
        lz_cur    = DISABLED;
        blink_cur = phase_q && blink_lo;
        case (idx_q)
            2'd0: begin
                digit_val = snap_q[3:0];
                lz_cur    = DISABLED;
                blink_cur = phase_q && blink_lo;
            end
            2'd1: begin
                digit_val = snap_q[7:4];
                lz_cur    = lz1;
                blink_cur = phase_q && blink_lo;
            end
            2'd2: begin
                digit_val = snap_q[11:8];
                lz_cur    = lz2;
                blink_cur = phase_q && blink_hi;
            end
            default: begin
                digit_val = snap_q[15:12];
                lz_cur    = lz3;
                blink_cur = phase_q && blink_hi;
            end
        endcase
        dp_cur = (idx_q == 2'd2) && sep_on && !blink_cur;
    end

    bcd_to_ssd u_bcd_to_ssd (
        .bcd (digit_val),
        .seg (digit_pat)
    );

    // next registered pin drive; zero-blanking keeps the separator dot lit
    always_comb begin
        ctl_d = SSD_DIGIT_OFF;
        seg_d = SSD_BLANK;
        if (live_q) begin
            ctl_d = ~(4'b0001 << idx_q);
            if (blink_cur) begin
                seg_d = SSD_BLANK;
            end else if (lz_cur) begin
                seg_d = {SSD_BLANK[7:1], ~dp_cur};
            end else begin
                seg_d = {digit_pat, ~dp_cur};
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= 2'd0;
            frame_q <= '0;
            phase_q <= 1'b0;
            live_q  <= DISABLED;
            snap_q  <= 16'h0000;
            ctl_q   <= SSD_DIGIT_OFF;
            seg_q   <= SSD_BLANK;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            live_q  <= live_d;
            snap_q  <= snap_d;
            ctl_q   <= ctl_d;
            seg_q   <= seg_d;
        end
    end

    assign ssd_ctl = ctl_q;
    assign ssd_seg = seg_q;

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the two-digit BCD up-counters.
- Takes two 8-bit packed-BCD values, high pair (e.g. minutes) and low pair (e.g. seconds), and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Provides tear-free snapshotting, leading-zero blanking, a separator dot and a blink option for setting modes.
- Sits between the counter chain and the board display pins.

Parameters:
- SCAN_DIV_W, 16: width of the free-running scan divider. The digit advances every 2^SCAN_DIV_W clocks.
- BLINK_SCANS_W, 6: width of the scan-frame counter. The blink phase toggles every 2^BLINK_SCANS_W full 4-digit frames.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous active-high reset
- cnt_hi  in  8  packed BCD, digits 3 (cnt_hi[7:4]) and 2 (cnt_hi[3:0])
- cnt_lo  in  8  packed BCD, digits 1 (cnt_lo[7:4]) and 0 (cnt_lo[3:0])
- blank_lead  in  1  enable leading-zero blanking
- sep_on  in  1  light the decimal point of digit 2 (mm.ss separator)
- blink_hi  in  1  blink digits 3..2
- blink_lo  in  1  blink digits 1..0
- ssd_ctl  out  4  digit enables, active-low, one-hot-zero; bit n = digit n
- ssd_seg  out  8  {a,b,c,d,e,f,g,dp}, active-low

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all of the following hold:
  - divider=0, idx=0, frame counter=0, blink phase=0, snapshot=16'h0000
  - ssd_ctl=4'b1111 (all digits off), ssd_seg=8'hFF
  - Release is synchronous to the next clk edge; no output glitch on assertion.
- Divider: increments every clk and wraps at 2^SCAN_DIV_W-1.
- Digit index: on the wrap cycle (div==max), idx increments on that edge, 3 wraps to 0.
- Snapshot: when idx wraps 3->0, {cnt_hi,cnt_lo} is captured into the snapshot on the same edge. The display never mixes digits from two counter values within one frame.
  - The first frame after reset shows the reset snapshot 0000.
  - The counter value is picked up at the first 3->0 wrap.
- Frame counter: increments on each idx 3->0 wrap. The blink phase toggles when the frame counter wraps.
- Output timing: ssd_ctl and ssd_seg are registered from the current idx and snapshot. They reflect a new idx exactly 1 clk after idx changes (latency 1). The first valid drive is 1 clk after the first idx change following reset.
- ssd_ctl = ~(4'b0001 << idx).
- Digit decode (value -> ssd_seg[7:1]; bit 0 = dp, 1 unless set):
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110, 4: 1001100
  - 5: 0100100, 6: 0100000, 7: 0001111, 8: 0000000, 9: 0000100
  - Values A..F (invalid BCD) show dash 1111110. An invalid value is displayed and never treated as zero for blanking.
- Leading-zero blanking, when blank_lead=1:
  - Digit 3 is blanked if its value is 0.
  - Digit 2 is blanked if digit 3 is blanked and its value is 0.
  - Digit 1 is blanked if digits 3 and 2 are blanked and its value is 0.
  - Digit 0 is never blanked.
  - A blanked digit shows ssd_seg=8'hFF, but ssd_ctl still strobes (constant scan duty).
- Blink: when blink phase=1 and blink_hi=1, digits 3..2 show 8'hFF. When blink phase=1 and blink_lo=1, digits 1..0 show 8'hFF.
- Separator: dp bit = 0 on digit 2 when sep_on=1 and digit 2 is not blink-blanked. Leading-zero blanking of digit 2 does not suppress dp.
- Inputs blank_lead, sep_on and blink_* are sampled live (not snapshotted) at each output register update.
- Reset asserted mid-frame: outputs go to 4'b1111/8'hFF immediately; the scan restarts at idx 0.

Decomposition:
- global.v gains the 7-segment pattern constants: SSD_0..SSD_9, SSD_DASH, SSD_BLANK (8-bit, dp=1).
- global.v gains SSD_DIGIT_OFF=4'b1111.
- Existing ENABLED/DISABLED constants are reused.
- One sub-module: bcd_to_ssd, a combinational 4-bit BCD to 7-bit segment decoder that includes the dash for invalid values. The parent adds blanking, blink and dp.

Test Plan:
- SCAN_DIV_W=2, hold rst=1 for 5 clk -> ssd_ctl=4'b1111, ssd_seg=8'hFF throughout.
- After release, cnt_hi=8'h12, cnt_lo=8'h34, blank_lead=0:
  - first frame -> all digits 8'h03 (zero pattern)
  - second frame -> ctl 1110/1101/1011/0111 with seg 8'h99 ('4'), 8'h0D ('3'), 8'h25 ('2'), 8'h9F ('1'), each held 4 clk.
- cnt_hi=8'h00, cnt_lo=8'h05, blank_lead=1 -> digits 3,2,1 = 8'hFF, digit 0 = 8'h49.
- Same inputs with sep_on=1 -> digit 2 = 8'hFE.
- Change cnt_lo from 8'h59 to 8'h00 while idx=1 -> the current frame still shows 5,9; the next frame shows 0,0 (no tearing).
- cnt_lo=8'h3C -> digit 0 shows dash 8'hFD.
- BLINK_SCANS_W=1, blink_lo=1 -> digits 1..0 alternate between their value and 8'hFF every 2 frames; digits 3..2 are unaffected.
- Assert rst at idx=2 mid-digit -> outputs are blank within the same cycle; after release the scan resumes from idx 0.
